shift_arbiter_2to1: RTL and testbench

Two-requester arbiter and sequencer for a single shared 32-bit variable logical left shifter. Two independent clients issue shift requests over valid/ready handshakes. The block grants one per cycle with round-robin priority and computes `val << shift`, zero-filled. It returns the result, tagged with the requester id, through a one-entry registered response slot with its own valid/ready handshake. It sits between the ALU-side issue logic and any consumer that needs shifted operands, so only one shifter instance is built.

---
 rtl/shift_arbiter_2to1.sv | 130 +++++++++++++
 tb/tb_shift_arbiter_2to1.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter_2to1.sv
// shift_arbiter_2to1: round-robin 2:1 arbiter in front of one shared W-bit
// logical left shifter, returning tagged results through a one-entry
// registered response slot.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   reqN_valid_i / reqN_ready_o   request handshake for requester N (0,1)
//   reqN_shift_i, reqN_val_i      shift amount and operand for requester N
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_id_o, rsp_result_o        producing requester and shifted result
//   grant_cnt0_o, grant_cnt1_o    saturating 16-bit grant counters, present
//                                 only when SHIFT_ARB_GRANT_CNT_EN is defined
module shift_arbiter_2to1 #(
    parameter int unsigned W  = 32,
    parameter int unsigned SW = 5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          req0_valid_i,
    output logic          req0_ready_o,
    input  logic [SW-1:0] req0_shift_i,
    input  logic [W-1:0]  req0_val_i,
    input  logic          req1_valid_i,
    output logic          req1_ready_o,
    input  logic [SW-1:0] req1_shift_i,
    input  logic [W-1:0]  req1_val_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic          rsp_id_o,
`ifdef SHIFT_ARB_GRANT_CNT_EN
    output logic [15:0]   grant_cnt0_o,
    output logic [15:0]   grant_cnt1_o,
`endif
    output logic [W-1:0]  rsp_result_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic           prio_q, prio_d;
    logic           id_q, id_d;
    logic [W-1:0]   result_q, result_d;
    logic           accept_en;
    logic           grant0, grant1;

    // Grant selection and next-state for the response slot and priority pointer.
    // rst_ni gates acceptance so readies are 0 throughout reset.
    always_comb begin
        accept_en = rst_ni && ((state_q == EMPTY) || rsp_ready_i);
        grant0    = 1'b0;
        grant1    = 1'b0;
        state_d   = state_q;
        prio_d    = prio_q;
        id_d      = id_q;
        result_d  = result_q;

        if (accept_en) begin
            if (req0_valid_i && req1_valid_i) begin
                grant0 = !prio_q;
                grant1 = prio_q;
            end else begin
                grant0 = req0_valid_i;
                grant1 = req1_valid_i;
            end
        end

        if (grant0) begin
            result_d = req0_val_i << req0_shift_i;
            id_d     = 1'b0;
            state_d  = FULL;
            prio_d   = 1'b1;
        end else if (grant1) begin
            result_d = req1_val_i << req1_shift_i;
            id_d     = 1'b1;
            state_d  = FULL;
            prio_d   = 1'b0;
        end else if ((state_q == FULL) && rsp_ready_i) begin
            state_d  = EMPTY;
        end
    end

    // Response slot and priority registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= EMPTY;
            prio_q   <= 1'b0;
            id_q     <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            id_q     <= id_d;
            result_q <= result_d;
        end
    end

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;
    assign rsp_valid_o  = (state_q == FULL);
    assign rsp_id_o     = id_q;
    assign rsp_result_o = result_q;

`ifdef SHIFT_ARB_GRANT_CNT_EN
    localparam int unsigned CW = 16;

    logic [CW-1:0] cnt0_q, cnt1_q;

    // Per-requester grant counters, saturating at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (req0_ready_o && req0_valid_i && (cnt0_q != '1)) begin
                cnt0_q <= cnt0_q + CW'(1);
            end
            if (req1_ready_o && req1_valid_i && (cnt1_q != '1)) begin
                cnt1_q <= cnt1_q + CW'(1);
            end
        end
    end

    assign grant_cnt0_o = cnt0_q;
    assign grant_cnt1_o = cnt1_q;
`endif

endmodule

// File: tb/tb_shift_arbiter_2to1.sv
// Directed self-checking bench for shift_arbiter_2to1. Inputs change 1 time
// unit after a rising edge; combinational readies are checked at the falling
// edge and registered outputs 1 time unit after the rising edge.
module tb_shift_arbiter_2to1;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [4:0]  req0_shift;
    logic [31:0] req0_val;
    logic        req1_valid, req1_ready;
    logic [4:0]  req1_shift;
    logic [31:0] req1_val;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_result;
`ifdef SHIFT_ARB_GRANT_CNT_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    shift_arbiter_2to1 #(.W(32), .SW(5)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req0_valid_i (req0_valid),
        .req0_ready_o (req0_ready),
        .req0_shift_i (req0_shift),
        .req0_val_i   (req0_val),
        .req1_valid_i (req1_valid),
        .req1_ready_o (req1_ready),
        .req1_shift_i (req1_shift),
        .req1_val_i   (req1_val),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
`ifdef SHIFT_ARB_GRANT_CNT_EN
        .grant_cnt0_o (grant_cnt0),
        .grant_cnt1_o (grant_cnt1),
`endif
        .rsp_result_o (rsp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic id, input logic [31:0] res);
        check({tag, ".valid"}, 32'(rsp_valid), 32'(v));
        check({tag, ".id"}, 32'(rsp_id), 32'(id));
        check({tag, ".result"}, rsp_result, res);
    endtask

    task automatic check_ready(input string tag, input logic r0, input logic r1);
        @(negedge clk);
        check({tag, ".ready0"}, 32'(req0_ready), 32'(r0));
        check({tag, ".ready1"}, 32'(req1_ready), 32'(r1));
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_shift = 5'd0; req0_val = 32'h0;
        req1_valid = 1'b1; req1_shift = 5'd0; req1_val = 32'h0;
        rsp_ready  = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        // Reset state, with both requesters valid to show readies forced low
        check_out("reset", 1'b0, 1'b0, 32'h0);
        check("reset.ready0", 32'(req0_ready), 32'd0);
        check("reset.ready1", 32'(req1_ready), 32'd0);
        do_reset();

        // Single request: 1 << 31
        req0_valid = 1'b1; req0_val = 32'h0000_0001; req0_shift = 5'd31;
        check_ready("single", 1'b1, 1'b0);
        step();
        req0_valid = 1'b0;
        check_out("single", 1'b1, 1'b0, 32'h8000_0000);

        // Shift extremes on requester 1, back-to-back
        req1_valid = 1'b1; req1_val = 32'hDEAD_BEEF; req1_shift = 5'd0;
        check_ready("sh0", 1'b0, 1'b1);
        step();
        check_out("sh0", 1'b1, 1'b1, 32'hDEAD_BEEF);
        req1_shift = 5'd4;
        check_ready("sh4", 1'b0, 1'b1);
        step();
        check_out("sh4", 1'b1, 1'b1, 32'hEADB_EEF0);
        req1_shift = 5'd31;
        check_ready("sh31", 1'b0, 1'b1);
        step();
        check_out("sh31", 1'b1, 1'b1, 32'h8000_0000);
        req1_valid = 1'b0;
        step();
        check("drain.valid", 32'(rsp_valid), 32'd0);
        check("drain.hold", rsp_result, 32'h8000_0000);

        // Contention after reset: grants alternate starting with requester 0
        do_reset();
        req0_valid = 1'b1; req0_val = 32'h11; req0_shift = 5'd1;
        req1_valid = 1'b1; req1_val = 32'h22; req1_shift = 5'd2;
        for (int i = 0; i < 6; i++) begin
            check_ready($sformatf("cont%0d", i), (i % 2) == 0, (i % 2) == 1);
            step();
            check_out($sformatf("cont%0d", i), 1'b1, (i % 2) == 1,
                      ((i % 2) == 0) ? 32'h22 : 32'h88);
        end

        // Backpressure: load 0x12345678 from requester 0, then stall
        req1_valid = 1'b0; req0_val = 32'h1234_5678; req0_shift = 5'd0;
        step();
        check_out("bp.load", 1'b1, 1'b0, 32'h1234_5678);
        rsp_ready  = 1'b0;
        req1_valid = 1'b1; req1_val = 32'h3; req1_shift = 5'd4;
        for (int i = 0; i < 3; i++) begin
            check_ready($sformatf("bp%0d", i), 1'b0, 1'b0);
            step();
            check_out($sformatf("bp%0d", i), 1'b1, 1'b0, 32'h1234_5678);
        end
        rsp_ready = 1'b1;
        check_ready("bp.release", 1'b0, 1'b1);
        step();
        check_out("bp.release", 1'b1, 1'b1, 32'h30);

        // Mid-operation reset while FULL with prio=1
        req1_valid = 1'b0; req0_val = 32'h5; req0_shift = 5'd1;
        step();
        check_out("mr.load", 1'b1, 1'b0, 32'hA);
        rsp_ready  = 1'b0;
        req1_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("mr.valid", 32'(rsp_valid), 32'd0);
        check("mr.ready0", 32'(req0_ready), 32'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mr.first0", 32'(req0_ready), 32'd1);
        check("mr.first1", 32'(req1_ready), 32'd0);
        step();
        check_out("mr.grant", 1'b1, 1'b0, 32'hA);

`ifdef SHIFT_ARB_GRANT_CNT_EN
        // Grant counters: 5 to req0, 3 to req1, then saturation
        do_reset();
        req0_valid = 1'b1;
        repeat (5) step();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        repeat (3) step();
        req1_valid = 1'b0;
        check("cnt0", 32'(grant_cnt0), 32'd5);
        check("cnt1", 32'(grant_cnt1), 32'd3);
        req0_valid = 1'b1;
        repeat (65530) step();
        check("cnt0.max", 32'(grant_cnt0), 32'hFFFF);
        step();
        check("cnt0.sat", 32'(grant_cnt0), 32'hFFFF);
        req0_valid = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
